// File: rtl/instr_encoder_pkg.sv
// ============================================================================
// Module      : instr_encoder_pkg
// Description : Shared type codes, RV32I opcodes and FIFO sizing for the
//               instruction encoder and the immediate generator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package instr_encoder_pkg;

    localparam logic [3:0] TYPE_R  = 4'b0001;
    localparam logic [3:0] TYPE_I0 = 4'b0010;
    localparam logic [3:0] TYPE_I1 = 4'b0011;
    localparam logic [3:0] TYPE_I2 = 4'b0100;
    localparam logic [3:0] TYPE_I3 = 4'b0101;
    localparam logic [3:0] TYPE_S  = 4'b0110;
    localparam logic [3:0] TYPE_B  = 4'b0111;
    localparam logic [3:0] TYPE_U  = 4'b1000;
    localparam logic [3:0] TYPE_J  = 4'b1001;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam int FIFO_DEPTH = 2;
    localparam int PAYLOAD_W  = 65;

    typedef struct packed {
        logic        err;
        logic [31:0] addr;
        logic [31:0] instr;
    } enc_word_t;

    // True when imm equals the sign-extension of imm[msb:0].
    function automatic logic sext_fits(input logic [31:0] imm, input int msb);
        logic [31:0] mask;
        logic [31:0] upper;
        mask  = 32'hFFFF_FFFF << msb;
        upper = imm & mask;
        return (upper == 32'h0) || (upper == mask);
    endfunction

endpackage

`default_nettype wire

// File: rtl/instr_encoder_fifo.sv
// ============================================================================
// Module      : enc_fifo
// Description : Two-entry FIFO carrying {err, addr, instr} encoder words.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module enc_fifo
    import instr_encoder_pkg::*;
#(
    parameter logic [PAYLOAD_W-1:0] RESET_WORD = '0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 push,
    input  logic [PAYLOAD_W-1:0] push_data,
    output logic                 full,
    input  logic                 pop,
    output logic                 out_valid,
    output logic [PAYLOAD_W-1:0] out_data
);

    logic [PAYLOAD_W-1:0] r_mem [FIFO_DEPTH];
    logic                 r_wr_ptr;
    logic                 r_rd_ptr;
    logic [1:0]           r_count;
    logic                 w_push;
    logic                 w_pop;

    assign w_pop  = pop && (r_count != 2'd0);
    // A pop on the same edge frees the slot the push lands in.
    assign w_push = push && ((r_count != 2'(FIFO_DEPTH)) || w_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= RESET_WORD;
            end
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= push_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign full      = (r_count == 2'(FIFO_DEPTH));
    assign out_valid = (r_count != 2'd0);
    assign out_data  = r_mem[r_rd_ptr];

endmodule

`default_nettype wire

// File: rtl/instr_encoder.sv
// ============================================================================
// Module      : instr_encoder
// Description : Packs RV32I fields and immediate into instruction words,
//               tags them with a word address and queues them in enc_fifo.
//               Optional macro IMM_RANGE_CHECK_EN flags out-of-range immediates.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_encoder #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enc_in_valid,
    output logic        enc_in_ready,
    input  logic [3:0]  enc_in_type,
    input  logic [6:0]  enc_in_opcode,
    input  logic [2:0]  enc_in_funct3,
    input  logic [6:0]  enc_in_funct7,
    input  logic [4:0]  enc_in_rd,
    input  logic [4:0]  enc_in_rs1,
    input  logic [4:0]  enc_in_rs2,
    input  logic [31:0] enc_in_imm,
    input  logic        enc_addr_clr,
    output logic        enc_out_valid,
    input  logic        enc_out_ready,
    output logic [31:0] enc_out_instr,
    output logic [31:0] enc_out_addr,
    output logic        enc_out_err
);
    import instr_encoder_pkg::*;

    logic [31:0] w_instr;
    logic        w_bad_type;
    logic        w_err;
    logic        w_accept;
    logic        w_full;
    logic [31:0] w_tag;
    logic [31:0] r_addr;
    enc_word_t   w_push_word;
    enc_word_t   w_head_word;
`ifdef IMM_RANGE_CHECK_EN
    logic        w_range_err;
`endif

    always_comb begin
        w_instr    = 32'h0;
        w_bad_type = 1'b0;
`ifdef IMM_RANGE_CHECK_EN
        w_range_err = 1'b0;
`endif
        case (enc_in_type)
            TYPE_R: w_instr = {enc_in_funct7, enc_in_rs2, enc_in_rs1, enc_in_funct3,
                               enc_in_rd, enc_in_opcode};
            TYPE_I0, TYPE_I1, TYPE_I2, TYPE_I3: begin
                w_instr = {enc_in_imm[11:0], enc_in_rs1, enc_in_funct3, enc_in_rd,
                           enc_in_opcode};
`ifdef IMM_RANGE_CHECK_EN
                w_range_err = !sext_fits(enc_in_imm, 11);
`endif
            end
            TYPE_S: begin
                w_instr = {enc_in_imm[11:5], enc_in_rs2, enc_in_rs1, enc_in_funct3,
                           enc_in_imm[4:0], enc_in_opcode};
`ifdef IMM_RANGE_CHECK_EN
                w_range_err = !sext_fits(enc_in_imm, 11);
`endif
            end
            TYPE_B: begin
                w_instr = {enc_in_imm[12], enc_in_imm[10:5], enc_in_rs2, enc_in_rs1,
                           enc_in_funct3, enc_in_imm[4:1], enc_in_imm[11], enc_in_opcode};
`ifdef IMM_RANGE_CHECK_EN
                w_range_err = !sext_fits(enc_in_imm, 12) || enc_in_imm[0];
`endif
            end
            TYPE_U: begin
                w_instr = {enc_in_imm[31:12], enc_in_rd, enc_in_opcode};
`ifdef IMM_RANGE_CHECK_EN
                w_range_err = (enc_in_imm[11:0] != 12'h0);
`endif
            end
            TYPE_J: begin
                w_instr = {enc_in_imm[20], enc_in_imm[10:1], enc_in_imm[11],
                           enc_in_imm[19:12], enc_in_rd, enc_in_opcode};
`ifdef IMM_RANGE_CHECK_EN
                w_range_err = !sext_fits(enc_in_imm, 20) || enc_in_imm[0];
`endif
            end
            default: w_bad_type = 1'b1;
        endcase
    end

`ifdef IMM_RANGE_CHECK_EN
    assign w_err = w_bad_type | w_range_err;
`else
    assign w_err = w_bad_type;
`endif

    assign enc_in_ready = !w_full;
    assign w_accept     = enc_in_valid && enc_in_ready;
    // A clear takes effect for the word accepted on the same edge.
    assign w_tag        = enc_addr_clr ? BASE_ADDR : r_addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr <= BASE_ADDR;
        end else if (w_accept) begin
            r_addr <= w_tag + 32'd4;
        end else if (enc_addr_clr) begin
            r_addr <= BASE_ADDR;
        end
    end

    assign w_push_word = '{err: w_err, addr: w_tag, instr: w_instr};

    enc_fifo #(
        .RESET_WORD ({1'b0, BASE_ADDR, 32'h0})
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (w_accept),
        .push_data (w_push_word),
        .full      (w_full),
        .pop       (enc_out_ready),
        .out_valid (enc_out_valid),
        .out_data  (w_head_word)
    );

    assign enc_out_instr = w_head_word.instr;
    assign enc_out_addr  = w_head_word.addr;
    assign enc_out_err   = w_head_word.err;

endmodule

`default_nettype wire

// File: tb/tb_instr_encoder.sv
// ============================================================================
// Module      : tb_instr_encoder
// Description : Self-checking bench for instr_encoder (directed + random).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enc_in_valid = 1'b0;
    logic        enc_in_ready;
    logic [3:0]  enc_in_type = 4'h0;
    logic [6:0]  enc_in_opcode = 7'h0;
    logic [2:0]  enc_in_funct3 = 3'h0;
    logic [6:0]  enc_in_funct7 = 7'h0;
    logic [4:0]  enc_in_rd = 5'h0;
    logic [4:0]  enc_in_rs1 = 5'h0;
    logic [4:0]  enc_in_rs2 = 5'h0;
    logic [31:0] enc_in_imm = 32'h0;
    logic        enc_addr_clr = 1'b0;
    logic        enc_out_valid;
    logic        enc_out_ready = 1'b0;
    logic [31:0] enc_out_instr;
    logic [31:0] enc_out_addr;
    logic        enc_out_err;

    // Second instance preloaded near the top of the address space.
    logic        w_in_valid = 1'b0;
    logic        w_in_ready;
    logic        w_addr_clr = 1'b0;
    logic        w_out_valid;
    logic        w_out_ready = 1'b1;
    logic [31:0] w_out_instr;
    logic [31:0] w_out_addr;
    logic        w_out_err;

    localparam logic [31:0] BASE   = 32'h0000_0000;
    localparam logic [31:0] W_BASE = 32'hFFFF_FFFC;

    int n_checks = 0;
    int n_fail   = 0;
    logic [64:0] exp_q [$];
    logic [31:0] mdl_addr = BASE;
    bit rand_phase = 1'b0;

    always #5 clk = ~clk;

    instr_encoder #(.BASE_ADDR(BASE)) dut (
        .clk(clk), .rst_n(rst_n),
        .enc_in_valid(enc_in_valid), .enc_in_ready(enc_in_ready),
        .enc_in_type(enc_in_type), .enc_in_opcode(enc_in_opcode),
        .enc_in_funct3(enc_in_funct3), .enc_in_funct7(enc_in_funct7),
        .enc_in_rd(enc_in_rd), .enc_in_rs1(enc_in_rs1), .enc_in_rs2(enc_in_rs2),
        .enc_in_imm(enc_in_imm), .enc_addr_clr(enc_addr_clr),
        .enc_out_valid(enc_out_valid), .enc_out_ready(enc_out_ready),
        .enc_out_instr(enc_out_instr), .enc_out_addr(enc_out_addr),
        .enc_out_err(enc_out_err)
    );

    instr_encoder #(.BASE_ADDR(W_BASE)) dut_w (
        .clk(clk), .rst_n(rst_n),
        .enc_in_valid(w_in_valid), .enc_in_ready(w_in_ready),
        .enc_in_type(4'b0010), .enc_in_opcode(7'b0010011),
        .enc_in_funct3(3'b000), .enc_in_funct7(7'h0),
        .enc_in_rd(5'd1), .enc_in_rs1(5'd0), .enc_in_rs2(5'd0),
        .enc_in_imm(32'd5), .enc_addr_clr(w_addr_clr),
        .enc_out_valid(w_out_valid), .enc_out_ready(w_out_ready),
        .enc_out_instr(w_out_instr), .enc_out_addr(w_out_addr),
        .enc_out_err(w_out_err)
    );

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference: returns {err, instr} from the format tables and signed ranges.
    function automatic logic [32:0] model_enc(input logic [3:0] t, input logic [6:0] opc,
                                              input logic [2:0] f3, input logic [6:0] f7,
                                              input logic [4:0] rd, input logic [4:0] rs1,
                                              input logic [4:0] rs2, input logic [31:0] imm);
        logic [31:0] w;
        logic        bad;
        logic        rng;
        int          s;
        s   = $signed(imm);
        w   = 32'h0;
        bad = 1'b0;
        rng = 1'b0;
        case (t)
            4'd1: w = {f7, rs2, rs1, f3, rd, opc};
            4'd2, 4'd3, 4'd4, 4'd5: begin
                w = {imm[11:0], rs1, f3, rd, opc};
                rng = (s < -2048) || (s > 2047);
            end
            4'd6: begin
                w = {imm[11:5], rs2, rs1, f3, imm[4:0], opc};
                rng = (s < -2048) || (s > 2047);
            end
            4'd7: begin
                w = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], opc};
                rng = (s < -4096) || (s > 4095) || (s % 2 != 0);
            end
            4'd8: begin
                w = {imm[31:12], rd, opc};
                rng = (imm % 4096) != 0;
            end
            4'd9: begin
                w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opc};
                rng = (s < -1048576) || (s > 1048575) || (s % 2 != 0);
            end
            default: bad = 1'b1;
        endcase
`ifdef IMM_RANGE_CHECK_EN
        return {bad | rng, w};
`else
        return {bad, w};
`endif
    endfunction

    // Scoreboard: observes pops and pushes that will happen at the next rising edge.
    always @(negedge clk) begin
        logic [64:0] e;
        logic [32:0] m;
        if (rst_n) begin
            if (enc_out_valid && enc_out_ready) begin
                if (exp_q.size() == 0) begin
                    check_eq("sb_unexpected_pop", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("sb_instr", {32'h0, enc_out_instr}, {32'h0, e[31:0]});
                    check_eq("sb_addr", {32'h0, enc_out_addr}, {32'h0, e[63:32]});
                    check_eq("sb_err", {63'h0, enc_out_err}, {63'h0, e[64]});
                end
            end
            if (enc_in_valid && enc_in_ready) begin
                m = model_enc(enc_in_type, enc_in_opcode, enc_in_funct3, enc_in_funct7,
                              enc_in_rd, enc_in_rs1, enc_in_rs2, enc_in_imm);
                e = {m[32], (enc_addr_clr ? BASE : mdl_addr), m[31:0]};
                exp_q.push_back(e);
                mdl_addr = e[63:32] + 32'd4;
            end else if (enc_addr_clr) begin
                mdl_addr = BASE;
            end
        end
    end

    always @(posedge clk) begin
        if (rand_phase) begin
            #1 enc_out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic send(input logic [3:0] t, input logic [6:0] opc, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [31:0] imm);
        bit done;
        done = 1'b0;
        enc_in_type = t; enc_in_opcode = opc; enc_in_funct3 = f3; enc_in_funct7 = f7;
        enc_in_rd = rd; enc_in_rs1 = rs1; enc_in_rs2 = rs2; enc_in_imm = imm;
        enc_in_valid = 1'b1;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (enc_in_ready) begin
                @(posedge clk);
                #1;
                done = 1'b1;
            end
        end
        enc_in_valid = 1'b0;
        if (!done) check_eq("send_timeout", 64'd0, 64'd1);
    endtask

    task automatic w_send(input logic clr, input logic [31:0] exp_addr, input string tag);
        check_eq({tag, "_ready"}, {63'h0, w_in_ready}, 64'd1);
        w_in_valid = 1'b1;
        w_addr_clr = clr;
        @(posedge clk);
        #1;
        w_in_valid = 1'b0;
        w_addr_clr = 1'b0;
        check_eq({tag, "_valid"}, {63'h0, w_out_valid}, 64'd1);
        check_eq(tag, {32'h0, w_out_addr}, {32'h0, exp_addr});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0]  t;
        logic [31:0] imm;
        int          cnt;
        logic        exp_rng_err;
`ifdef IMM_RANGE_CHECK_EN
        exp_rng_err = 1'b1;
`else
        exp_rng_err = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_valid", {63'h0, enc_out_valid}, 64'd0);
        check_eq("rst_instr", {32'h0, enc_out_instr}, 64'd0);
        check_eq("rst_addr", {32'h0, enc_out_addr}, {32'h0, BASE});
        check_eq("rst_err", {63'h0, enc_out_err}, 64'd0);
        check_eq("rst_w_addr", {32'h0, w_out_addr}, {32'h0, W_BASE});
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_eq("rst_ready", {63'h0, enc_in_ready}, 64'd1);

        // Backpressure with three known encodings.
        enc_out_ready = 1'b0;
        send(4'b0010, 7'b0010011, 3'b000, 7'h0, 5'd1, 5'd0, 5'd0, 32'd5);
        check_eq("addi_valid", {63'h0, enc_out_valid}, 64'd1);
        check_eq("addi_instr", {32'h0, enc_out_instr}, 64'h0050_0093);
        check_eq("addi_addr", {32'h0, enc_out_addr}, {32'h0, BASE});
        check_eq("addi_err", {63'h0, enc_out_err}, 64'd0);
        send(4'b0110, 7'b0100011, 3'b010, 7'h0, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC);
        check_eq("full_ready_low", {63'h0, enc_in_ready}, 64'd0);
        enc_in_type = 4'b1001; enc_in_opcode = 7'b1101111; enc_in_funct3 = 3'b000;
        enc_in_rd = 5'd1; enc_in_rs1 = 5'd0; enc_in_rs2 = 5'd0; enc_in_imm = 32'd8;
        enc_in_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("held_ready_low", {63'h0, enc_in_ready}, 64'd0);
        check_eq("head_stable", {32'h0, enc_out_instr}, 64'h0050_0093);
        enc_out_ready = 1'b1;
        @(posedge clk);
        #1;
        check_eq("ready_after_pop", {63'h0, enc_in_ready}, 64'd1);
        check_eq("store_instr", {32'h0, enc_out_instr}, 64'hFE20_AE23);
        check_eq("store_addr", {32'h0, enc_out_addr}, {32'h0, BASE + 32'd4});
        @(posedge clk);
        #1;
        enc_in_valid = 1'b0;
        check_eq("jal_instr", {32'h0, enc_out_instr}, 64'h0080_00EF);
        check_eq("jal_addr", {32'h0, enc_out_addr}, {32'h0, BASE + 32'd8});

        // Range and illegal-type errors.
        send(4'b0010, 7'b0010011, 3'b000, 7'h0, 5'd1, 5'd0, 5'd0, 32'd2048);
        check_eq("rng_instr", {32'h0, enc_out_instr}, 64'h8000_0093);
        check_eq("rng_err", {63'h0, enc_out_err}, {63'h0, exp_rng_err});
        send(4'b1111, 7'b0010011, 3'b000, 7'h0, 5'd1, 5'd0, 5'd0, 32'd5);
        check_eq("illegal_instr", {32'h0, enc_out_instr}, 64'h0);
        check_eq("illegal_err", {63'h0, enc_out_err}, 64'd1);

        // Randomized traffic with backpressure and clears.
        rand_phase = 1'b1;
        for (int n = 0; n < 300; n++) begin
            cnt = $urandom_range(0, 19);
            if (cnt < 17) t = 4'($urandom_range(1, 9));
            else if (cnt == 17) t = 4'h0;
            else t = 4'($urandom_range(10, 15));
            case ($urandom_range(0, 3))
                0: imm = $urandom();
                1: imm = 32'($urandom_range(0, 8191)) - 32'd4096;
                2: imm = (32'($urandom_range(0, 4095)) - 32'd2048) & 32'hFFFF_FFFE;
                default: imm = $urandom() & 32'hFFFF_F000;
            endcase
            enc_addr_clr = ($urandom_range(0, 15) == 0);
            send(t, 7'($urandom()), 3'($urandom()), 7'($urandom()), 5'($urandom()),
                 5'($urandom()), 5'($urandom()), imm);
            enc_addr_clr = 1'b0;
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
        rand_phase = 1'b0;
        @(posedge clk);
        #2;
        enc_out_ready = 1'b1;
        cnt = 0;
        while (exp_q.size() != 0 && cnt < 20) begin
            @(posedge clk);
            cnt++;
        end
        #1;
        check_eq("drain_empty", 64'(exp_q.size()), 64'd0);
        check_eq("drain_valid", {63'h0, enc_out_valid}, 64'd0);

        // Asynchronous reset in the middle of traffic.
        enc_out_ready = 1'b0;
        send(4'b1000, 7'b0110111, 3'b000, 7'h0, 5'd3, 5'd0, 5'd0, 32'h1234_5000);
        check_eq("pre_rst_valid", {63'h0, enc_out_valid}, 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("midrst_valid", {63'h0, enc_out_valid}, 64'd0);
        exp_q.delete();
        mdl_addr = BASE;
        @(posedge clk);
        #1 rst_n = 1'b1;
        enc_out_ready = 1'b1;
        #1;
        check_eq("post_rst_ready", {63'h0, enc_in_ready}, 64'd1);

        // Address wrap and clear on the preloaded instance.
        w_send(1'b0, 32'hFFFF_FFFC, "wrap_first");
        w_send(1'b0, 32'h0000_0000, "wrap_second");
        w_send(1'b0, 32'h0000_0004, "wrap_third");
        w_send(1'b1, W_BASE, "clr_accept");
        w_send(1'b0, 32'h0000_0000, "after_clr");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/instr_encoder.md
# instr_encoder

Packs decoded instruction fields and a 32-bit immediate into RV32I instruction words. It is the inverse of the core's immediate generator: it scatters the immediate into the bit positions that the generator gathers from. It sits between the boot loader / test sequencer and instruction memory, taking field records over a valid/ready handshake. Each record leaves as an encoded word with a word-aligned write address through a 2-entry output FIFO.

## Interface
Parameters:
- BASE_ADDR, 32'h0000_0000, address given to the first word after reset or clear; must be word-aligned.

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- enc_in_valid  in  1  input record valid
- enc_in_ready  out  1  encoder can accept a record
- enc_in_type  in  4  0001 R, 0010–0101 I, 0110 S, 0111 B, 1000 U, 1001 J; all other codes are illegal
- enc_in_opcode  in  7  opcode field
- enc_in_funct3  in  3  funct3 field
- enc_in_funct7  in  7  funct7 field (R only)
- enc_in_rd / enc_in_rs1 / enc_in_rs2  in  5 each  register fields
- enc_in_imm  in  32  signed byte-offset immediate
- enc_addr_clr  in  1  synchronous reset of the address counter to BASE_ADDR
- enc_out_valid  out  1  FIFO head is valid
- enc_out_ready  in  1  consumer takes the head
- enc_out_instr  out  32  encoded word
- enc_out_addr  out  32  write address of the word
- enc_out_err  out  1  word had an illegal type or an out-of-range immediate

## Operation
- Handshake:
  - A record is accepted when enc_in_valid && enc_in_ready.
  - A word is popped when enc_out_valid && enc_out_ready.
  - Once enc_out_valid is asserted, the head holds stable until it is popped.
- Encoding is combinational on the input. The result is written into the FIFO on the accept edge.
  - R: {funct7, rs2, rs1, funct3, rd, opcode}
  - I: {imm[11:0], rs1, funct3, rd, opcode}
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}
  - B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}
  - U: {imm[31:12], rd, opcode}
  - J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}
  - Illegal type: instr = 32'h0, err = 1.
- Immediate bits outside a format's field are ignored in the encoded word.
- Words flagged with err are still emitted and still consume an address.
- Address counter:
  - Each accepted word is tagged with the current count, then the count advances by 4.
  - The count wraps modulo 2^32 (32'hFFFF_FFFC → 32'h0).
  - enc_addr_clr with a simultaneous accept: the accepted word gets BASE_ADDR and the count becomes BASE_ADDR+4.
  - enc_addr_clr without an accept: the count becomes BASE_ADDR.
- FIFO: 2 entries, with a read pointer, a write pointer and a 2-bit occupancy count.
  - enc_in_ready = (count != 2).
  - Push and pop on the same edge leave the count unchanged. This is legal even when the FIFO is full, since the pop frees the slot.

## Timing
- Reset values: enc_out_valid 0, enc_out_instr 32'h0, enc_out_addr BASE_ADDR, enc_out_err 0, count 0, address counter BASE_ADDR. enc_in_ready is 1 once reset is released.
- Latency: a record accepted at edge N with the FIFO empty appears with enc_out_valid = 1 in the cycle after edge N.
- Throughput: 1 word per cycle while enc_out_ready is held high.
- When the FIFO is full, enc_in_ready drops in the cycle after the second push. It rises again in the cycle after a pop.
- Reset asserted mid-operation immediately empties the FIFO and drops enc_out_valid. Words in flight are lost.

## Configuration
- IMM_RANGE_CHECK_EN defined: enc_out_err is also set when the immediate does not fit its format.
  - I/S: imm is not the sign-extension of imm[11:0].
  - B: imm is not the sign-extension of imm[12:0], or imm[0] ≠ 0.
  - J: imm is not the sign-extension of imm[20:0], or imm[0] ≠ 0.
  - U: imm[11:0] ≠ 0.
  - R: never out of range.
- IMM_RANGE_CHECK_EN undefined: enc_out_err reflects illegal type only. Immediates are silently truncated.

## Structure
- Shared package holds:
  - type code constants (TYPE_R, TYPE_I0–TYPE_I3, TYPE_S, TYPE_B, TYPE_U, TYPE_J)
  - RV32I opcode constants
  - the FIFO depth constant (2)
- The package's type codes are the same ones the immediate generator consumes.
- One sub-module: enc_fifo, a 2-entry FIFO with a 65-bit payload {err, addr, instr}. The encoder itself is the combinational packer plus the address counter.

## Test plan
- Encode I-type addi: type 0010, opcode 0010011, funct3 000, rd 1, rs1 0, imm 5 → instr 32'h0050_0093, addr BASE_ADDR, err 0.
- Encode S-type store: type 0110, opcode 0100011, funct3 010, rs1 1, rs2 2, imm -4 → instr 32'hFE20_AE23, addr BASE_ADDR+4.
- Encode J-type: type 1001, opcode 1101111, rd 1, imm 8 → instr 32'h0080_00EF.
- Range error: I-type as in the first case but imm 2048 → instr 32'h8000_0093. err = 1 with IMM_RANGE_CHECK_EN defined, 0 without it. Illegal type 1111 → instr 0, err 1 in both builds.
- Backpressure: hold enc_out_ready low and send 3 records back-to-back.
  - enc_in_ready is low after 2 pushes.
  - Release enc_out_ready: words pop in order with addresses BASE, +4, +8, and the third record is accepted only after the first pop.
- Clear and wrap: preload the counter to 32'hFFFF_FFFC via BASE_ADDR.
  - Two accepts tag words FFFF_FFFC then 0000_0000.
  - enc_addr_clr together with an accept tags that word BASE_ADDR.
  - rst_n low mid-stream makes enc_out_valid 0 immediately.
